// File: rtl/ram_arbiter_nm.sv
// ram_arbiter_nm
//   N-master arbiter for a shared single-port RAM bus. Masters request
//   ownership with req_i. The winner is chosen by round-robin or by fixed
//   priority (lowest index). It keeps the grant until it drops its request
//   with idle high. An optional hold limit revokes the grant when another
//   master is waiting. The granted master's RAM-side signals pass straight
//   through to the RAM port.
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_i, idle_i                 per-master request / transfer-finished flag
//   grant_o                       registered one-hot grant
//   owner_o                       index of the granted master (valid while |grant_o)
//   timeout_err_o                 1-cycle pulse when a grant is revoked by MAX_HOLD
//   m_cs_i/m_wen_i/m_oen_i        per-master RAM strobes (cs high, wen/oen low active)
//   m_address_i, m_dataout_i      packed per-master address / write data
//   ram_*_o                       muxed RAM bus, idle defaults when nothing is granted
module ram_arbiter_nm #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_MASTERS-1:0]          req_i,
  input  logic [N_MASTERS-1:0]          idle_i,
  output logic [N_MASTERS-1:0]          grant_o,
  output logic [$clog2(N_MASTERS)-1:0]  owner_o,
  output logic                          timeout_err_o,
  input  logic [N_MASTERS-1:0]          m_cs_i,
  input  logic [N_MASTERS-1:0]          m_wen_i,
  input  logic [N_MASTERS-1:0]          m_oen_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dataout_i,
  output logic                          ram_cs_o,
  output logic                          ram_wen_o,
  output logic                          ram_oen_o,
  output logic [ADDR_W-1:0]             ram_address_o,
  output logic [DATA_W-1:0]             ram_datain_o
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_RELEASE} state_e;

  state_e                 state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   terr_q, terr_d;

  logic [IDX_W-1:0]       win, win_nxt;
  logic                   others_req;

  // Unpack the per-master buses so the owner index can select them directly.
  logic [ADDR_W-1:0] addr_a [N_MASTERS];
  logic [DATA_W-1:0] data_a [N_MASTERS];
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign addr_a[i] = m_address_i[i*ADDR_W +: ADDR_W];
    assign data_a[i] = m_dataout_i[i*DATA_W +: DATA_W];
  end

  // Winner search. Offsets are scanned from the far end back to the start,
  // so the request nearest the start position is written last and wins.
  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    if (RR_MODE != 0) begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        idx = int'(ptr_q) + i;
        if (idx >= N_MASTERS) idx = idx - N_MASTERS;
        if (req_i[idx]) win = IDX_W'(idx);
      end
    end else begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (req_i[i]) win = IDX_W'(i);
      end
    end
    win_nxt = (int'(win) == N_MASTERS - 1) ? '0 : win + 1'b1;
  end

  assign others_req = |(req_i & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d      = S_GRANTED;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          hold_d       = '0;
          if (RR_MODE != 0) ptr_d = win_nxt;
        end
      end
      S_GRANTED: begin
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        // A voluntary release takes precedence over a revoke in the same cycle.
        if (!req_i[owner_q] && idle_i[owner_q]) begin
          state_d = S_RELEASE;
          grant_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_req) begin
          state_d = S_RELEASE;
          grant_d = '0;
          terr_d  = 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      terr_q  <= terr_d;
    end
  end

  assign grant_o       = grant_q;
  assign owner_o       = owner_q;
  assign timeout_err_o = terr_q;

  // Zero-latency pass-through of the owner's bus. grant_q is cleared in
  // RELEASE, so the turnaround cycle drives the defaults.
  always_comb begin
    ram_cs_o      = 1'b0;
    ram_wen_o     = 1'b1;
    ram_oen_o     = 1'b1;
    ram_address_o = '0;
    ram_datain_o  = '0;
    if (|grant_q) begin
      ram_cs_o      = m_cs_i[owner_q];
      ram_wen_o     = m_wen_i[owner_q];
      ram_oen_o     = m_oen_i[owner_q];
      ram_address_o = addr_a[owner_q];
      ram_datain_o  = data_a[owner_q];
    end
  end

endmodule

// File: tb/tb_ram_arbiter_nm.sv
module tb_ram_arbiter_nm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_a = '0, idle_a = 4'hF, req_b = '0, idle_b = 4'hF;
  logic [3:0]  m_cs  = 4'b1111;
  logic [3:0]  m_wen = 4'b1101;
  logic [3:0]  m_oen = 4'b1010;
  logic [31:0] m_addr = 32'h43_32_2A_10;
  logic [31:0] m_data = 32'hD3_C2_55_A0;

  logic [3:0] grant_a, grant_b;
  logic [1:0] owner_a, owner_b;
  logic       terr_a, terr_b;
  logic       cs_a, wen_a, oen_a, cs_b, wen_b, oen_b;
  logic [7:0] addr_a, data_a, addr_b, data_b;

  always #5 clk = ~clk;

  // A: round-robin with a 4-cycle hold limit. B: fixed priority, no limit.
  ram_arbiter_nm #(.N_MASTERS(4), .ADDR_W(8), .DATA_W(8), .RR_MODE(1), .MAX_HOLD(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .idle_i(idle_a),
    .grant_o(grant_a), .owner_o(owner_a), .timeout_err_o(terr_a),
    .m_cs_i(m_cs), .m_wen_i(m_wen), .m_oen_i(m_oen),
    .m_address_i(m_addr), .m_dataout_i(m_data),
    .ram_cs_o(cs_a), .ram_wen_o(wen_a), .ram_oen_o(oen_a),
    .ram_address_o(addr_a), .ram_datain_o(data_a));

  ram_arbiter_nm #(.N_MASTERS(4), .ADDR_W(8), .DATA_W(8), .RR_MODE(0), .MAX_HOLD(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .idle_i(idle_b),
    .grant_o(grant_b), .owner_o(owner_b), .timeout_err_o(terr_b),
    .m_cs_i(m_cs), .m_wen_i(m_wen), .m_oen_i(m_oen),
    .m_address_i(m_addr), .m_dataout_i(m_data),
    .ram_cs_o(cs_b), .ram_wen_o(wen_b), .ram_oen_o(oen_b),
    .ram_address_o(addr_b), .ram_datain_o(data_b));

  typedef struct {
    bit         sel;
    logic [3:0] g;
    int         o;
    logic       te;
    logic       cs, wen, oen;
    logic [7:0] a, d;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.sel) begin
        chk("A.grant", 32'(grant_a), 32'(e.g));
        chk("A.owner", 32'(owner_a), 32'(e.o));
        chk("A.terr",  32'(terr_a),  32'(e.te));
        chk("A.cs",    32'(cs_a),    32'(e.cs));
        chk("A.wen",   32'(wen_a),   32'(e.wen));
        chk("A.oen",   32'(oen_a),   32'(e.oen));
        chk("A.addr",  32'(addr_a),  32'(e.a));
        chk("A.data",  32'(data_a),  32'(e.d));
      end else begin
        chk("B.grant", 32'(grant_b), 32'(e.g));
        chk("B.owner", 32'(owner_b), 32'(e.o));
        chk("B.terr",  32'(terr_b),  32'(e.te));
        chk("B.cs",    32'(cs_b),    32'(e.cs));
        chk("B.addr",  32'(addr_b),  32'(e.a));
      end
    end
  end

  // Drive this cycle's inputs and queue the outputs expected in this same
  // cycle (grant state reflects inputs driven by the previous step).
  task automatic step(input bit sel, input logic r, input logic [3:0] rq, input logic [3:0] id,
                      input logic [3:0] eg, input int eo, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    if (sel) begin req_b = rq; idle_b = id; end
    else     begin req_a = rq; idle_a = id; end
    e.sel = sel; e.g = eg; e.o = eo; e.te = et;
    if (eg != 4'b0000) begin
      e.cs = m_cs[eo]; e.wen = m_wen[eo]; e.oen = m_oen[eo];
      e.a = m_addr[eo*8 +: 8]; e.d = m_data[eo*8 +: 8];
    end else begin
      e.cs = 1'b0; e.wen = 1'b1; e.oen = 1'b1; e.a = 8'h00; e.d = 8'h00;
    end
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles: everything idle, bus at defaults.
    step(0, 1, 4'b0000, 4'hF, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 4'hF, 4'b0000, 0, 0);

    // Single request from master 1; its bus passes through while granted.
    step(0, 0, 4'b0010, 4'b1101, 4'b0000, 0, 0);
    step(0, 0, 4'b0010, 4'b1101, 4'b0010, 1, 0);
    step(0, 0, 4'b0010, 4'b1101, 4'b0010, 1, 0);
    step(0, 0, 4'b0000, 4'hF,    4'b0010, 1, 0);
    step(0, 0, 4'b0000, 4'hF,    4'b0000, 1, 0);  // RELEASE, owner holds
    step(0, 0, 4'b0000, 4'hF,    4'b0000, 1, 0);  // IDLE
    step(0, 1, 4'b0000, 4'hF,    4'b0000, 1, 0);  // reset pointer
    step(0, 0, 4'b0000, 4'hF,    4'b0000, 0, 0);

    // Round-robin: all request, each owner drops after one granted cycle.
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 0, 0);
    step(0, 0, 4'b1110, 4'hF, 4'b0001, 0, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 0, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 0, 0);
    step(0, 0, 4'b1101, 4'hF, 4'b0010, 1, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 1, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 1, 0);
    step(0, 0, 4'b1011, 4'hF, 4'b0100, 2, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 2, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 2, 0);
    step(0, 0, 4'b0111, 4'hF, 4'b1000, 3, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 3, 0);
    step(0, 0, 4'b1111, 4'hF, 4'b0000, 3, 0);
    step(0, 0, 4'b0000, 4'hF, 4'b0001, 0, 0);   // wrapped back to master 0
    step(0, 0, 4'b0000, 4'hF, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 4'hF, 4'b0000, 0, 0);   // pointer now 1

    // Hold limit: master 2 holds while master 3 waits.
    step(0, 0, 4'b1100, 4'b1011, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 4'b1100, 4'b1011, 4'b0100, 2, 0);
    step(0, 0, 4'b1100, 4'b1011, 4'b0000, 2, 1);  // revoked, error pulse
    step(0, 0, 4'b1100, 4'b1011, 4'b0000, 2, 0);
    step(0, 0, 4'b0000, 4'hF,    4'b1000, 3, 0);  // two cycles after drop
    step(0, 0, 4'b0000, 4'hF,    4'b0000, 3, 0);
    step(0, 0, 4'b0000, 4'hF,    4'b0000, 3, 0);

    // No competitor: grant persists past the limit with no error.
    step(0, 0, 4'b0100, 4'b1011, 4'b0000, 3, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 4'b0100, 4'b1011, 4'b0100, 2, 0);

    // Reset mid-grant, then 0110 goes to master 1 from a cleared pointer.
    step(0, 1, 4'b0100, 4'b1011, 4'b0100, 2, 0);
    step(0, 0, 4'b0110, 4'b1101, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 4'b1101, 4'b0010, 1, 0);  // req dropped, idle low
    step(0, 0, 4'b0000, 4'hF,    4'b0010, 1, 0);  // still held
    step(0, 0, 4'b0000, 4'hF,    4'b0000, 1, 0);
    step(0, 0, 4'b0000, 4'hF,    4'b0000, 1, 0);

    // Fixed priority: master 0 wins every round.
    step(1, 0, 4'b1111, 4'hF, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 4'b1110, 4'hF, 4'b0001, 0, 0);
      step(1, 0, 4'b1111, 4'hF, 4'b0000, 0, 0);
      step(1, 0, 4'b1111, 4'hF, 4'b0000, 0, 0);
    end
    step(1, 0, 4'b0000, 4'hF, 4'b0001, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
